ball_engine: RTL and testbench
==============================

Name: ball_engine

Overview:
- Parametrised ball motion engine for the pong datapath; successor to the fixed-speed bouncing ball.
- Produces the ball's upper-left X/Y once per frame tick; reflects off top/bottom walls and both paddles.
- Detects goals at the left/right edges, pulses a score event, then re-serves from centre after a programmable delay.
- Speeds up on each paddle hit, up to a cap; sits between the paddle controllers and the VGA renderer/scorekeeper.

Parameters:
- SCREEN_W, 640, active width in pixels
- SCREEN_H, 480, active height in pixels
- WALL, 14, thickness of top/bottom wall and goal-line offset
- X_W, 10, width of X coordinate
- Y_W, 9, width of Y coordinate
- SPD_W, 6, width of the speed registers
- INIT_SPEED, 3, dx/dy after reset and at each serve
- MAX_SPEED, 12, dx saturation value
- PADDLE_L_X, 30, X of the left paddle's right face
- PADDLE_R_X, 610, X of the right paddle's left face
- SERVE_TICKS, 60, frame ticks held in SERVE before launch

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset; reset==0 at a clk edge resets the block
- frame_tick  in  1  one-cycle update strobe (one per frame)
- width  in  6  ball size in pixels, 0-63, sampled every cycle
- paddle_l_y  in  Y_W  top Y of the left paddle
- paddle_r_y  in  Y_W  top Y of the right paddle
- paddle_h  in  Y_W  height of both paddles
- outX  out  X_W  ball upper-left X
- outY  out  Y_W  ball upper-left Y
- dir_x  out  1  1 = moving left (X decreasing)
- dir_y  out  1  1 = moving up (Y decreasing)
- speed  out  SPD_W  current dx
- hit  out  1  one-cycle pulse on a paddle reflection
- score_l  out  1  one-cycle pulse when the left player scores
- score_r  out  1  one-cycle pulse when the right player scores
- serving  out  1  high while in SERVE

Behaviour:
- Reset (reset==0): outX=SCREEN_W/2-10-(width>>1), outY=SCREEN_H/2-(width>>1), dx=dy=INIT_SPEED, dir_x=1, dir_y=1, state=SERVE, serve counter=0, hit/score_l/score_r=0, serving=1.
- Reset takes priority over everything, including a frame_tick in the same cycle.
- All updates occur only on clk edges where frame_tick=1. Pulse outputs are registered, last exactly one cycle and are 0 otherwise.
- SERVE:
  - Hold position at the centre value; recompute it from the current width each tick.
  - Count frame_ticks. On the SERVE_TICKS-th tick, go to PLAY with dx=dy=INIT_SPEED; dir_x/dir_y keep their values.
  - The first movement happens on the next tick.
- PLAY X (use one-bit-wider signed arithmetic, so no wrap-around):
  - Next X is nx = outX-dx if dir_x, else outX+dx.
  - Vertical overlap with a paddle: outY+width > paddle_y and outY < paddle_y+paddle_h.
  - Left paddle hit: dir_x=1, outX>=PADDLE_L_X, nx<=PADDLE_L_X and overlap with the left paddle -> outX=PADDLE_L_X, dir_x=0, hit=1, dx=min(dx+1,MAX_SPEED).
  - Right paddle hit: dir_x=0, outX+width<=PADDLE_R_X, nx+width>=PADDLE_R_X and overlap with the right paddle -> outX=PADDLE_R_X-width, dir_x=1, hit=1, dx increments with the same saturation.
  - Left goal: otherwise, if nx<WALL -> score_r=1, state=SERVE, counter=0, dir_x=0 (serve toward the scorer).
  - Right goal: if nx+width>SCREEN_W-WALL -> score_l=1, state=SERVE, counter=0, dir_x=1.
  - Otherwise outX=nx.
- PLAY Y, evaluated in the same tick:
  - Next Y is ny = outY-dy if dir_y, else outY+dy.
  - If ny<WALL -> outY=WALL, dir_y=0.
  - Else if ny+width>SCREEN_H-WALL -> outY=SCREEN_H-WALL-width, dir_y=1.
  - Else outY=ny.
  - On a goal tick, outX/outY take the centre values instead.
- Simultaneous events: a wall bounce and a paddle hit in the same tick are both applied (corner case). A paddle hit beats a goal.
- dy stays constant. dx saturates and never exceeds MAX_SPEED.

Decomposition:
- Shared package pong_pkg:
  - state enum {SERVE, PLAY}
  - screen/wall constants
  - coordinate widths
- Sub-module ball_axis: one per axis. It computes next position, clamp and reflect for a given low/high bound and returns a bounce flag. The paddle and goal logic stays in the top level.

Test Plan:
- reset=0 with width=10, then release; 60 ticks -> outX=305, outY=235, serving=1 throughout. Tick 61 -> outY=232, outX=302.
- PLAY, outY=16, dir_y=1, dy=3 -> outY=14, dir_y=0. Next tick -> outY=17.
- Left paddle at y=200 with paddle_h=64; ball outX=32, outY=220, dir_x=1, dx=3 -> outX=30, dir_x=0, hit pulse, speed=4.
- Same geometry but paddle_l_y=400 -> no hit. The ball proceeds, and the tick with nx<14 gives a score_r pulse, serving=1 and a centred ball.
- 12 consecutive paddle hits from INIT_SPEED=3 -> speed climbs to 12 and stays 12.
- Drop reset to 0 mid-PLAY in the same cycle as frame_tick -> the reset values above apply and no pulse is emitted.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared ball state type, screen geometry and coordinate widths
package pong_pkg;
   typedef enum logic {SERVE, PLAY} state_t;
   localparam int PONG_W    = 640;
   localparam int PONG_H    = 480;
   localparam int PONG_WALL = 14;
   localparam int PONG_X_W  = 10;
   localparam int PONG_Y_W  = 9;
endpackage

// File: rtl/ball_axis.sv
// ball_axis: one axis of ball motion; next position, bound test and clamp/reflect into [LO, HI-size]
module ball_axis
   import pong_pkg::*;
#(
   parameter int W     = PONG_X_W,
   parameter int SPD_W = 6,
   parameter int LO    = PONG_WALL,
   parameter int HI    = PONG_W - PONG_WALL
) (
   input  logic [W-1:0]        pos,
   input  logic                dir,
   input  logic [SPD_W-1:0]    step,
   input  logic [5:0]          size,
   output logic signed [W+1:0] nxt,
   output logic                lo_hit,
   output logic                bounce,
   output logic [W-1:0]        pos_o,
   output logic                dir_o
);
   localparam logic signed [W+1:0] LO_S = (W+2)'(LO);
   localparam logic signed [W+1:0] HI_S = (W+2)'(HI);
   logic signed [W+1:0] pos_s, step_s, size_s;
   logic                hi_hit;
   always_comb begin
      pos_s  = $signed((W+2)'(pos));
      step_s = $signed((W+2)'(step));
      size_s = $signed((W+2)'(size));
      nxt    = dir ? pos_s - step_s : pos_s + step_s;
      lo_hit = nxt < LO_S;
      hi_hit = nxt + size_s > HI_S;
      bounce = lo_hit | hi_hit;
      pos_o  = lo_hit ? W'(LO) : hi_hit ? W'(HI) - W'(size) : nxt[W-1:0];
      dir_o  = lo_hit ? 1'b0 : hi_hit ? 1'b1 : dir;
   end
endmodule

// File: rtl/ball_engine.sv
// ball_engine: per-frame ball motion with wall and paddle reflection, goal detection
// and a timed re-serve from the centre of the screen.
module ball_engine
   import pong_pkg::*;
#(
   parameter int SCREEN_W    = PONG_W,
   parameter int SCREEN_H    = PONG_H,
   parameter int WALL        = PONG_WALL,
   parameter int X_W         = PONG_X_W,
   parameter int Y_W         = PONG_Y_W,
   parameter int SPD_W       = 6,
   parameter int INIT_SPEED  = 3,
   parameter int MAX_SPEED   = 12,
   parameter int PADDLE_L_X  = 30,
   parameter int PADDLE_R_X  = 610,
   parameter int SERVE_TICKS = 60
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_tick,
   input  logic [5:0]       width,
   input  logic [Y_W-1:0]   paddle_l_y,
   input  logic [Y_W-1:0]   paddle_r_y,
   input  logic [Y_W-1:0]   paddle_h,
   output logic [X_W-1:0]   outX,
   output logic [Y_W-1:0]   outY,
   output logic             dir_x,
   output logic             dir_y,
   output logic [SPD_W-1:0] speed,
   output logic             hit,
   output logic             score_l,
   output logic             score_r,
   output logic             serving
);
   localparam int CNT_W = $clog2(SERVE_TICKS + 1);
   localparam logic signed [X_W+1:0] PL_S = (X_W+2)'(PADDLE_L_X);
   localparam logic signed [X_W+1:0] PR_S = (X_W+2)'(PADDLE_R_X);
   localparam logic [SPD_W-1:0] INIT = SPD_W'(INIT_SPEED);
   localparam logic [SPD_W-1:0] MAXS = SPD_W'(MAX_SPEED);

   state_t           state_q, state_d;
   logic [X_W-1:0]   x_q, x_d, cx;
   logic [Y_W-1:0]   y_q, y_d, cy;
   logic             dirx_q, dirx_d, diry_q, diry_d;
   logic [SPD_W-1:0] dx_q, dx_d, dx_inc;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit_q, hit_d, scl_q, scl_d, scr_q, scr_d;

   logic signed [X_W+1:0] x_nxt, xs, ws;
   logic signed [Y_W+1:0] y_nxt;
   logic                  x_lo, x_bounce, x_dir, y_lo, y_bounce, y_dir;
   logic [X_W-1:0]        x_pos;
   logic [Y_W-1:0]        y_pos;
   logic [Y_W:0]          y_bot;
   logic                  ov_l, ov_r, hit_l, hit_r;
   logic                  sig_unused;

   ball_axis #(.W(X_W), .SPD_W(SPD_W), .LO(WALL), .HI(SCREEN_W - WALL)) u_x (
      .pos(x_q), .dir(dirx_q), .step(dx_q), .size(width),
      .nxt(x_nxt), .lo_hit(x_lo), .bounce(x_bounce), .pos_o(x_pos), .dir_o(x_dir)
   );

   ball_axis #(.W(Y_W), .SPD_W(SPD_W), .LO(WALL), .HI(SCREEN_H - WALL)) u_y (
      .pos(y_q), .dir(diry_q), .step(INIT), .size(width),
      .nxt(y_nxt), .lo_hit(y_lo), .bounce(y_bounce), .pos_o(y_pos), .dir_o(y_dir)
   );

   assign sig_unused = ^{x_pos, y_nxt, y_lo, y_bounce};

   always_comb begin
      cx     = X_W'(SCREEN_W / 2 - 10) - X_W'(width >> 1);
      cy     = Y_W'(SCREEN_H / 2) - Y_W'(width >> 1);
      xs     = $signed((X_W+2)'(x_q));
      ws     = $signed((X_W+2)'(width));
      y_bot  = (Y_W+1)'(y_q) + (Y_W+1)'(width);
      ov_l   = y_bot > (Y_W+1)'(paddle_l_y) && (Y_W+1)'(y_q) < (Y_W+1)'(paddle_l_y) + (Y_W+1)'(paddle_h);
      ov_r   = y_bot > (Y_W+1)'(paddle_r_y) && (Y_W+1)'(y_q) < (Y_W+1)'(paddle_r_y) + (Y_W+1)'(paddle_h);
      hit_l  = dirx_q && xs >= PL_S && x_nxt <= PL_S && ov_l;
      hit_r  = !dirx_q && xs + ws <= PR_S && x_nxt + ws >= PR_S && ov_r;
      dx_inc = dx_q >= MAXS ? MAXS : dx_q + SPD_W'(1);
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      dirx_d  = dirx_q;
      diry_d  = diry_q;
      dx_d    = dx_q;
      cnt_d   = cnt_q;
      hit_d   = 1'b0;
      scl_d   = 1'b0;
      scr_d   = 1'b0;
      if (frame_tick && state_q == SERVE) begin
         x_d   = cx;
         y_d   = cy;
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(SERVE_TICKS - 1)) begin
            state_d = PLAY;
            dx_d    = INIT;
         end
      end else if (frame_tick) begin
         y_d    = y_pos;
         diry_d = y_dir;
         // a paddle hit wins over a goal; the goal side comes from the X axis bound that tripped
         if (hit_l || hit_r) begin
            x_d    = hit_l ? X_W'(PADDLE_L_X) : X_W'(PADDLE_R_X) - X_W'(width);
            dirx_d = hit_r;
            hit_d  = 1'b1;
            dx_d   = dx_inc;
         end else if (x_bounce) begin
            x_d     = cx;
            y_d     = cy;
            dirx_d  = x_dir;
            scr_d   = x_lo;
            scl_d   = !x_lo;
            state_d = SERVE;
            cnt_d   = '0;
         end else begin
            x_d = x_nxt[X_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= SERVE;
         x_q     <= cx;
         y_q     <= cy;
         dirx_q  <= 1'b1;
         diry_q  <= 1'b1;
         dx_q    <= INIT;
         cnt_q   <= '0;
         hit_q   <= 1'b0;
         scl_q   <= 1'b0;
         scr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dirx_q  <= dirx_d;
         diry_q  <= diry_d;
         dx_q    <= dx_d;
         cnt_q   <= cnt_d;
         hit_q   <= hit_d;
         scl_q   <= scl_d;
         scr_q   <= scr_d;
      end
   end

   assign outX    = x_q;
   assign outY    = y_q;
   assign dir_x   = dirx_q;
   assign dir_y   = diry_q;
   assign speed   = dx_q;
   assign hit     = hit_q;
   assign score_l = scl_q;
   assign score_r = scr_q;
   assign serving = state_q == SERVE;
endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: directed scenarios plus random play, checked every cycle against
// an integer model of the ball's motion rules.
module tb_ball_engine;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_tick = 1'b0;
   logic [5:0] width = 6'd10;
   logic [8:0] paddle_l_y = '0;
   logic [8:0] paddle_r_y = '0;
   logic [8:0] paddle_h = '0;
   logic [9:0] outX;
   logic [8:0] outY;
   logic       dir_x, dir_y;
   logic [5:0] speed;
   logic       hit, score_l, score_r, serving;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;
   int mx, my, mdx, mcnt;
   bit mdirx, mdiry, mserv, mhit, msl, msr;

   always #5 clk = ~clk;

   ball_engine dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .width(width),
      .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y), .paddle_h(paddle_h),
      .outX(outX), .outY(outY), .dir_x(dir_x), .dir_y(dir_y), .speed(speed),
      .hit(hit), .score_l(score_l), .score_r(score_r), .serving(serving)
   );

   task automatic model_step();
      int w, cx, cy, nx, ny, pl, pr, ph;
      bit goal;
      w = int'(width); cx = 310 - w / 2; cy = 240 - w / 2;
      pl = int'(paddle_l_y); pr = int'(paddle_r_y); ph = int'(paddle_h);
      mhit = 0; msl = 0; msr = 0; goal = 0;
      if (!reset) begin
         mx = cx; my = cy; mdx = 3; mdirx = 1; mdiry = 1; mserv = 1; mcnt = 0;
      end else if (frame_tick && mserv) begin
         mx = cx; my = cy; mcnt++;
         if (mcnt == 60) begin mserv = 0; mdx = 3; end
      end else if (frame_tick) begin
         nx = mdirx ? mx - mdx : mx + mdx;
         ny = mdiry ? my - 3 : my + 3;
         if (mdirx && mx >= 30 && nx <= 30 && my + w > pl && my < pl + ph) begin
            mx = 30; mdirx = 0; mhit = 1; mdx = (mdx + 1 > 12) ? 12 : mdx + 1;
         end else if (!mdirx && mx + w <= 610 && nx + w >= 610 && my + w > pr && my < pr + ph) begin
            mx = 610 - w; mdirx = 1; mhit = 1; mdx = (mdx + 1 > 12) ? 12 : mdx + 1;
         end else if (nx < 14) begin
            msr = 1; goal = 1; mdirx = 0;
         end else if (nx + w > 626) begin
            msl = 1; goal = 1; mdirx = 1;
         end else mx = nx;
         if (ny < 14) begin my = 14; mdiry = 0; end
         else if (ny + w > 466) begin my = 466 - w; mdiry = 1; end
         else my = ny;
         if (goal) begin mx = cx; my = cy; mserv = 1; mcnt = 0; end
      end
   endtask

   task automatic cyc(input bit ft, input bit rn);
      reset = rn;
      frame_tick = ft;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic expect_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if ({outX, outY, dir_x, dir_y, speed, hit, score_l, score_r, serving} !==
             {10'(mx), 9'(my), mdirx, mdiry, 6'(mdx), mhit, msl, msr, mserv}) begin
            errors++;
            $display("FAIL model t=%0t got x=%0d y=%0d dx=%b dy=%b spd=%0d hit=%b sl=%b sr=%b srv=%b want x=%0d y=%0d dx=%b dy=%b spd=%0d hit=%b sl=%b sr=%b srv=%b",
                     $time, outX, outY, dir_x, dir_y, speed, hit, score_l, score_r, serving,
                     mx, my, mdirx, mdiry, mdx, mhit, msl, msr, mserv);
         end
         checks++;
         if (speed > 6'd12) begin
            errors++;
            $display("FAIL speed_cap got %0d want <=12", speed);
         end
      end
   end

   initial begin
      bit srv_all;
      paddle_h = 9'd64; paddle_l_y = 9'd40; paddle_r_y = 9'd0;
      cyc(0, 0);
      cyc(1, 0);
      chk_en = 1;
      expect_eq("reset_x", int'(outX), 305);
      expect_eq("reset_y", int'(outY), 235);
      expect_eq("reset_serving", int'(serving), 1);
      expect_eq("reset_speed", int'(speed), 3);
      srv_all = 1;
      repeat (59) begin cyc(1, 1); srv_all &= serving; end
      expect_eq("serve_hold", int'(srv_all), 1);
      cyc(1, 1);
      expect_eq("launch_x", int'(outX), 305);
      expect_eq("launch_serving", int'(serving), 0);
      cyc(1, 1);
      expect_eq("move1_x", int'(outX), 302);
      expect_eq("move1_y", int'(outY), 232);
      repeat (72) cyc(1, 1);
      expect_eq("pre_wall_y", int'(outY), 16);
      cyc(1, 1);
      expect_eq("wall_y", int'(outY), 14);
      expect_eq("wall_dir_y", int'(dir_y), 0);
      cyc(1, 1);
      expect_eq("after_wall_y", int'(outY), 17);
      repeat (16) cyc(1, 1);
      expect_eq("pre_hit_x", int'(outX), 32);
      cyc(1, 1);
      expect_eq("hit_x", int'(outX), 30);
      expect_eq("hit_dir_x", int'(dir_x), 0);
      expect_eq("hit_pulse", int'(hit), 1);
      expect_eq("hit_speed", int'(speed), 4);
      cyc(1, 1);
      expect_eq("hit_pulse_end", int'(hit), 0);

      // reset with a coincident tick mid-play, then a miss at the left paddle
      paddle_l_y = 9'd400;
      cyc(1, 0);
      expect_eq("midrst_x", int'(outX), 305);
      expect_eq("midrst_y", int'(outY), 235);
      expect_eq("midrst_serving", int'(serving), 1);
      expect_eq("midrst_speed", int'(speed), 3);
      expect_eq("midrst_dirs", int'({dir_x, dir_y}), 3);
      expect_eq("midrst_pulses", int'({hit, score_l, score_r}), 0);
      repeat (157) cyc(1, 1);
      expect_eq("pre_goal_x", int'(outX), 14);
      cyc(1, 1);
      expect_eq("goal_score_r", int'(score_r), 1);
      expect_eq("goal_score_l", int'(score_l), 0);
      expect_eq("goal_serving", int'(serving), 1);
      expect_eq("goal_x", int'(outX), 305);
      expect_eq("goal_y", int'(outY), 235);
      expect_eq("goal_dir_x", int'(dir_x), 0);
      cyc(1, 1);
      expect_eq("goal_pulse_end", int'(score_r), 0);

      // full-height paddles: every arrival is a hit, so speed climbs and saturates
      paddle_l_y = 9'd0; paddle_r_y = 9'd0; paddle_h = 9'd511;
      cyc(1, 0);
      repeat (4060) cyc(1, 1);
      expect_eq("sat_speed", int'(speed), 12);
      expect_eq("sat_in_play", int'(serving), 0);

      paddle_h = 9'd120;
      cyc(1, 0);
      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(0, 199) == 0) width = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 49) == 0) paddle_l_y = 9'($urandom_range(0, 420));
         if ($urandom_range(0, 49) == 0) paddle_r_y = 9'($urandom_range(0, 420));
         if ($urandom_range(0, 999) == 0) paddle_h = 9'($urandom_range(0, 511));
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4999) != 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
